// File: rtl/sb_stream_arb.sv
// -----------------------------------------------------------------------------
// sb_stream_arb
//
// N-to-1 packet-aware round-robin arbiter for switchboard streams. Several
// requesters share one SB TX port. Once a port wins, the grant stays with it
// until the beat carrying last=1 is accepted. The output goes through a
// one-entry register slot that can be popped and reloaded in the same cycle,
// so a continuous stream still moves one beat per cycle.
//
// Parameters:
//   N     - number of requester ports (2..16)
//   DW    - data width in bits
//   DESTW - dest field width in bits
//
// Ports:
//   clk        in   clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   in_data    in   N*DW     requester data, port i at [i*DW +: DW]
//   in_dest    in   N*DESTW  requester dest, port i at [i*DESTW +: DESTW]
//   in_last    in   N        end-of-packet flag per port
//   in_valid   in   N        beat valid per port
//   in_ready   out  N        beat accepted per port (at most one bit high)
//   out_data   out  DW       registered data
//   out_dest   out  DESTW    registered dest
//   out_last   out  1        registered last
//   out_valid  out  1        output slot full
//   out_ready  in   1        downstream ready
//   grant_idx  out  clog2(N) current or most recently granted port
//   locked     out  1        high while a multi-beat packet is in progress
//
// Optional feature (macro SB_STREAM_ARB_SRC_TAG_EN):
//   When defined, the top clog2(N) bits of out_dest are replaced with the
//   index of the granted port, so the consumer can route responses back to
//   the requester. When undefined, in_dest passes through unchanged.
// -----------------------------------------------------------------------------
module sb_stream_arb #(
  parameter int N     = 4,
  parameter int DW    = 256,
  parameter int DESTW = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N*DW-1:0]        in_data,
  input  logic [N*DESTW-1:0]     in_dest,
  input  logic [N-1:0]           in_last,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  output logic [DW-1:0]          out_data,
  output logic [DESTW-1:0]       out_dest,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   grant_idx,
  output logic                   locked
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Unpacked views of the flattened request buses.
  logic [DW-1:0]    data_arr [N];
  logic [DESTW-1:0] dest_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign data_arr[gi] = in_data[gi*DW +: DW];
    assign dest_arr[gi] = in_dest[gi*DESTW +: DESTW];
  end

  state_e           state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [DESTW-1:0] out_dest_q, out_dest_d;
  logic             out_last_q, out_last_d;

  logic             slot_free;
  logic             rr_found;
  logic [IW-1:0]    rr_pick;
  logic [IW-1:0]    sel;
  logic [N-1:0]     ready_c;
  logic             accept;
  logic [DESTW-1:0] sel_dest;

  // The slot can take a new beat when empty or when it is being drained now.
  assign slot_free = !out_valid_q || out_ready;

  // Round-robin search: first valid port after rr_ptr, wrapping modulo N.
  always_comb begin : p_search
    int idx;
    rr_found = 1'b0;
    rr_pick  = '0;
    idx      = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!rr_found && in_valid[IW'(idx)]) begin
        rr_found = 1'b1;
        rr_pick  = IW'(idx);
      end
    end
  end

  // Inside a packet the owner keeps the grant; otherwise the search result.
  assign sel = (state_q == LOCKED) ? grant_q : rr_pick;

`ifdef SB_STREAM_ARB_SRC_TAG_EN
  assign sel_dest = {sel, dest_arr[sel][DESTW-IW-1:0]};
`else
  assign sel_dest = dest_arr[sel];
`endif

  always_comb begin
    ready_c     = '0;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_dest_d  = out_dest_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (rr_found && slot_free) begin
          ready_c[rr_pick] = 1'b1;
        end
      end
      LOCKED: begin
        // No preemption: the owner holds ready even while it bubbles.
        if (slot_free) begin
          ready_c[grant_q] = 1'b1;
        end
      end
      default: begin
        ready_c = '0;
      end
    endcase

    accept = |(ready_c & in_valid);

    if (accept) begin
      // Covers both an empty slot and a pop-and-reload in the same cycle.
      out_valid_d = 1'b1;
      out_data_d  = data_arr[sel];
      out_dest_d  = sel_dest;
      out_last_d  = in_last[sel];
      grant_d     = sel;
      if (in_last[sel]) begin
        state_d  = IDLE;
        rr_ptr_d = sel;
      end else begin
        state_d  = LOCKED;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IW'(N - 1);
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dest_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_dest_q  <= out_dest_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_dest  = out_dest_q;
  assign out_last  = out_last_q;
  assign grant_idx = grant_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_sb_stream_arb.sv
module tb_sb_stream_arb;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DESTW = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N*DW-1:0]      in_data;
  logic [N*DESTW-1:0]   in_dest;
  logic [N-1:0]         in_last;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [DW-1:0]        out_data;
  logic [DESTW-1:0]     out_dest;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           grant_idx;
  logic                 locked;

  logic [DW-1:0]        d  [N];
  logic [DESTW-1:0]     ds [N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_data[i*DW +: DW]       = d[i];
      in_dest[i*DESTW +: DESTW] = ds[i];
    end
  end

  sb_stream_arb #(.N(N), .DW(DW), .DESTW(DESTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_dest  (out_dest),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_idx (grant_idx),
    .locked    (locked)
  );

  // ---------------------------------------------------------------------------
  // Reference model: expected slot contents plus the arbitration rules
  // (owner of an open packet, else first valid port after the last served).
  // ---------------------------------------------------------------------------
  bit             m_valid;
  logic [DW-1:0]  m_data;
  logic [DESTW-1:0] m_dest;
  bit             m_last;
  int             m_grant;
  int             m_rr;
  int             m_owner;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_data  = '0;
    m_dest  = '0;
    m_last  = 0;
    m_grant = 0;
    m_rr    = N - 1;
    m_owner = -1;
  endtask

  // Called at the negedge: compare, then advance the model across the edge.
  task automatic finish_cycle(input string tag);
    bit         free, found, acc;
    int         cand, p;
    logic [N-1:0] er;
    free  = !m_valid || out_ready;
    found = 0;
    cand  = 0;
    if (m_owner >= 0) begin
      found = 1;
      cand  = m_owner;
    end else begin
      for (int k = 1; k <= N; k++) begin
        p = (m_rr + k) % N;
        if (!found && in_valid[p]) begin
          found = 1;
          cand  = p;
        end
      end
    end
    er = '0;
    if (free && found) er[cand] = 1'b1;
    check({tag, ".in_ready"},  64'(in_ready),  64'(er));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".grant_idx"}, 64'(grant_idx), 64'(m_grant));
    check({tag, ".locked"},    64'(locked),    64'(m_owner >= 0));
    if (m_valid) begin
      check({tag, ".out_data"}, 64'(out_data), 64'(m_data));
      check({tag, ".out_dest"}, 64'(out_dest), 64'(m_dest));
      check({tag, ".out_last"}, 64'(out_last), 64'(m_last));
    end
    acc = free && found && in_valid[cand];
    if (reset) begin
      model_reset();
    end else if (acc) begin
      $display("%s: beat port=%0d data=%h last=%0d", tag, cand, d[cand], in_last[cand]);
      m_valid = 1;
      m_data  = d[cand];
`ifdef SB_STREAM_ARB_SRC_TAG_EN
      m_dest  = {2'(cand), ds[cand][DESTW-3:0]};
`else
      m_dest  = ds[cand];
`endif
      m_last  = in_last[cand];
      m_grant = cand;
      if (in_last[cand]) begin
        m_owner = -1;
        m_rr    = cand;
      end else begin
        m_owner = cand;
      end
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors applied straight after reset (out_ready held high).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [3:0]  ready;
    logic        ovalid;
    logic [1:0]  grant;
    logic        lock;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [14];
  logic [31:0] single_vals [3];
  logic [31:0] held;
  int          acc_cnt;
  logic [31:0] exp_tag_dest;

  initial begin
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
    tbl[1]  = '{4'b1111, 4'b1111, 4'b0001, 1'b0, 2'd0, 1'b0, 32'h0};
    tbl[2]  = '{4'b1111, 4'b1111, 4'b0010, 1'b1, 2'd0, 1'b0, 32'hA0};
    tbl[3]  = '{4'b1111, 4'b1111, 4'b0100, 1'b1, 2'd1, 1'b0, 32'hA1};
    tbl[4]  = '{4'b1111, 4'b1111, 4'b1000, 1'b1, 2'd2, 1'b0, 32'hA2};
    tbl[5]  = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 2'd3, 1'b0, 32'hA3};
    tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 32'hA0};
    tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
    tbl[8]  = '{4'b0011, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b0, 32'h0};
    tbl[9]  = '{4'b0001, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b1, 32'hA1};
    tbl[10] = '{4'b0001, 4'b0000, 4'b0010, 1'b0, 2'd1, 1'b1, 32'h0};
    tbl[11] = '{4'b0011, 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b1, 32'h0};
    tbl[12] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd1, 1'b0, 32'hA1};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 32'hA0};
    single_vals[0] = 32'h11;
    single_vals[1] = 32'h22;
    single_vals[2] = 32'h33;

    reset     = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      d[i]  = 32'hA0 + 32'(i);
      ds[i] = 32'h100 + 32'(i);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Reset then idle.
    for (int c = 0; c < 10; c++) begin
      #4;
      check("idle.out_valid", 64'(out_valid), 64'd0);
      check("idle.in_ready",  64'(in_ready),  64'd0);
      check("idle.locked",    64'(locked),    64'd0);
      finish_cycle("idle");
    end

    // Round-robin rotation followed by a locked packet with bubbles.
    for (int r = 0; r < 14; r++) begin
      in_valid = tbl[r].valid;
      in_last  = tbl[r].last;
      #4;
      check("vec.in_ready",  64'(in_ready),  64'(tbl[r].ready));
      check("vec.out_valid", 64'(out_valid), 64'(tbl[r].ovalid));
      check("vec.grant_idx", 64'(grant_idx), 64'(tbl[r].grant));
      check("vec.locked",    64'(locked),    64'(tbl[r].lock));
      if (tbl[r].ovalid) check("vec.out_data", 64'(out_data), 64'(tbl[r].data));
      finish_cycle("vec");
    end

    // Single requester: port 2, three single-beat packets back to back.
    for (int k = 0; k < 4; k++) begin
      in_valid = (k < 3) ? 4'b0100 : 4'b0000;
      in_last  = 4'b0100;
      ds[2]    = 32'h5;
      if (k < 3) d[2] = single_vals[k];
      #4;
      if (k > 0) begin
        check("single.out_data",  64'(out_data),  64'(single_vals[k-1]));
        check("single.grant_idx", 64'(grant_idx), 64'd2);
      end
      finish_cycle("single");
    end

    // Backpressure: downstream stalls for 5 cycles while port 3 streams.
    acc_cnt   = 0;
    out_ready = 1'b0;
    in_valid  = 4'b1000;
    in_last   = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      d[3] = 32'h3000 + 32'(k);
      #4;
      if (in_ready[3]) acc_cnt++;
      if (k == 1) held = out_data;
      if (k > 1) check("bp.stable", 64'(out_data), 64'(held));
      finish_cycle("bp");
    end
    check("bp.captured", 64'(acc_cnt), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d[3] = 32'h3100 + 32'(k);
      #4;
      check("bp.resume_ready", 64'(in_ready), 64'b1000);
      finish_cycle("bp");
    end
    in_valid = '0;
    #4;
    finish_cycle("bp");

    // Reset on the second beat of a 3-beat packet from port 1.
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    #4;
    finish_cycle("rst");
    reset = 1'b1;
    #4;
    finish_cycle("rst");
    reset    = 1'b0;
    in_valid = 4'b0011;
    in_last  = 4'b0011;
    #4;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.locked",    64'(locked),    64'd0);
    check("rst.port0_wins", 64'(in_ready), 64'b0001);
    finish_cycle("rst");
    in_valid = '0;
    #4;
    finish_cycle("rst");

    // Source tag: port 3 sends dest 7.
`ifdef SB_STREAM_ARB_SRC_TAG_EN
    exp_tag_dest = 32'hC000_0007;
`else
    exp_tag_dest = 32'h0000_0007;
`endif
    ds[3]    = 32'h0000_0007;
    in_valid = 4'b1000;
    in_last  = 4'b1000;
    #4;
    finish_cycle("tag");
    in_valid = '0;
    #4;
    check("tag.out_dest", 64'(out_dest), 64'(exp_tag_dest));
    finish_cycle("tag");

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom) | 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        d[i]  = $urandom;
        ds[i] = $urandom;
      end
      #4;
      finish_cycle("rand");
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
